multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multicycle control FSM for the RV32I core datapath: PC, instruction memory, register file,
//  ALU operand muxes, data memory and writeback mux. Replaces per-edge opcode decode with a
//  FETCH/DECODE/EXEC/MEM/WB sequence, supports variable-latency memories via a req/ready
//  handshake, and traps on unsupported opcodes or memory timeouts. Emits all datapath enables.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for mem_ready in FETCH/MEM; 0 = never time out
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk           in   1      clock, rising-edge
//  reset         in   1      asynchronous, active-high reset
//  instr         in   32     instruction from instruction memory / IR
//  mem_ready     in   1      memory has completed the current request
//  branch_taken  in   1      branch unit result for the current SB instruction
//  mem_req       out  1      memory request; FETCH (imem) or MEM (dmem)
//  ir_we         out  1      latch instruction (fetch completion)
//  pc_we         out  1      update PC (exactly one pulse per retired instruction)
//  pc_src        out  1      0 = PC+4, 1 = ALU result
//  rf_we         out  1      register file write enable
//  dm_we         out  1      data memory write enable
//  sel_a         out  1      ALU operand A: 0 = PC, 1 = rs1
//  sel_b         out  1      ALU operand B: 0 = rs2, 1 = immediate
//  wb_sel        out  2      00 = DM data, 01 = ALU, 10 = PC+4
//  alu_func3     out  3      ALU/DM funct3, latched in DECODE
//  alu_subsra    out  1      instr[30] for R-type, else 0
//  illegal       out  1      sticky: unsupported opcode seen
//  timeout       out  1      sticky: memory did not answer within MEM_TIMEOUT
//  retired       out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
//  state         out  3      FSM state (debug)
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. State, latched fields, wait
//    counter, flags and retired are registers. Other outputs decode combinationally from them.
//  - Reset (async): state=FETCH, fields/counter/retired/flags=0. All outputs are 0 while reset is high.
//  - FETCH: mem_req=1 until mem_ready is sampled high. On that cycle ir_we=1 and next state is DECODE.
//  - DECODE: latch opcode, funct3, instr[30]. Opcodes:
//    0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch -> EXEC.
//    Any other opcode -> TRAP with illegal=1.
//  - EXEC: sel_a=1 (branch: 0), sel_b=0 for R (1 otherwise), func3 and subsra driven.
//    Branch: pc_we=1, pc_src=branch_taken, retire -> FETCH.
//    R/I -> WB. Load/store -> MEM.
//  - MEM: mem_req=1; dm_we=1 for store only, while mem_req is high. Advances on mem_ready.
//    Load -> WB. Store: pc_we=1, pc_src=0, retire -> FETCH.
//  - WB: rf_we=1, pc_we=1, pc_src=0; wb_sel=00 load / 01 R,I; retire -> FETCH.
//    rd=x0 is not special-cased.
//  - Retire: retired increments on the same edge as pc_we. Wraps from all-ones to 0.
//  - Wait counter: cleared on entry to FETCH/MEM, increments each cycle without mem_ready.
//    When it reaches MEM_TIMEOUT with mem_ready low -> TRAP, timeout=1. mem_ready on the same
//    cycle the limit is reached wins (no trap).
//  - TRAP: absorbing; all enables and mem_req are 0; only reset exits.
//  - Reset mid-operation (any state, incl. mem_req high): return to FETCH immediately;
//    no pc_we/rf_we/dm_we is issued for the aborted instruction.
//  - Latency with mem_ready=1: branch 3, R/I 4, store 4, load 5 cycles. Each stall cycle adds 1.
// TESTING
//  1. mem_ready=1, instr=0x002081B3 (add x3,x1,x2) -> states 0,1,2,4; rf_we+pc_we in cycle 4
//     only; wb_sel=01, sel_b=0; retired=1.
//  2. instr=0x0000A103 (lw), mem_ready low 3 cycles in MEM -> mem_req high 4 MEM cycles,
//     then WB with wb_sel=00; 8 cycles total; dm_we=0 throughout.
//  3. instr=0x0020A023 (sw) -> dm_we=1 only in MEM; pc_we on the mem_ready cycle; rf_we never high.
//  4. beq, branch_taken=1 -> pc_we=1, pc_src=1, sel_a=0 in EXEC; with branch_taken=0 -> pc_src=0; 3 cycles.
//  5. instr=0x0000006F (unsupported) -> TRAP, illegal=1, no pc_we/rf_we/dm_we.
//     mem_ready stuck low in FETCH -> TRAP after 16 cycles with timeout=1. Reset -> FETCH, flags cleared.
//  6. Assert reset in MEM of a sw with mem_req high -> mem_req, dm_we drop asynchronously;
//     retired unchanged (0); FETCH after release.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an RV32I datapath.
// Drives every datapath enable, handles req/ready memory latency and traps on bad opcodes or timeouts.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             rf_we,
    output logic             dm_we,
    output logic             sel_a,
    output logic             sel_b,
    output logic [1:0]       wb_sel,
    output logic [2:0]       alu_func3,
    output logic             alu_subsra,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_I      = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_BRANCH = 3'd4
    } op_class_t;

    state_t            r_state;
    op_class_t         r_class;
    logic [2:0]        r_funct3;
    logic              r_subsra;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_retired;

    state_t            w_next;
    op_class_t         w_dec_class;
    logic              w_dec_valid;
    logic              w_wait_expired;
    logic              w_set_illegal;
    logic              w_set_timeout;
    logic              w_mem_req;
    logic              w_ir_we;
    logic              w_pc_we;
    logic              w_pc_src;
    logic              w_rf_we;
    logic              w_dm_we;
    logic              w_sel_a;
    logic              w_sel_b;
    logic [1:0]        w_wb_sel;
    logic              w_unused_instr;

    assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // A zero limit disables the timeout; the counter then stays parked at 0.
    assign w_wait_expired = (MEM_TIMEOUT != 0) && (r_wait == WAIT_MAX) && !mem_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_dec_valid = 1'b1;
        w_dec_class = C_R;
        case (instr[6:0])
            OP_R:      w_dec_class = C_R;
            OP_I:      w_dec_class = C_I;
            OP_LOAD:   w_dec_class = C_LOAD;
            OP_STORE:  w_dec_class = C_STORE;
            OP_BRANCH: w_dec_class = C_BRANCH;
            default:   w_dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        w_mem_req     = 1'b0;
        w_ir_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_src      = 1'b0;
        w_rf_we       = 1'b0;
        w_dm_we       = 1'b0;
        w_sel_a       = 1'b0;
        w_sel_b       = 1'b0;
        w_wb_sel      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_wait_expired) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_DECODE: begin
                if (w_dec_valid) begin
                    w_next = S_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_EXEC: begin
                w_sel_a = (r_class != C_BRANCH);
                w_sel_b = (r_class != C_R);
                case (r_class)
                    C_BRANCH: begin
                        w_pc_we  = 1'b1;
                        w_pc_src = branch_taken;
                        w_next   = S_FETCH;
                    end
                    C_LOAD, C_STORE: w_next = S_MEM;
                    default:         w_next = S_WB;
                endcase
            end
            S_MEM: begin
                // Operands stay on rs1+imm so the address is stable for the whole access.
                w_sel_a   = 1'b1;
                w_sel_b   = 1'b1;
                w_mem_req = 1'b1;
                w_dm_we   = (r_class == C_STORE);
                if (mem_ready) begin
                    if (r_class == C_STORE) begin
                        w_pc_we = 1'b1;
                        w_next  = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_expired) begin
                    w_set_timeout = 1'b1;
                    w_next        = S_TRAP;
                end
            end
            S_WB: begin
                w_sel_a  = 1'b1;
                w_sel_b  = (r_class != C_R);
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_wb_sel = (r_class == C_LOAD) ? 2'b00 : 2'b01;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_class   <= C_R;
            r_funct3  <= 3'd0;
            r_subsra  <= 1'b0;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class  <= w_dec_class;
                r_funct3 <= instr[14:12];
                r_subsra <= instr[30] && (instr[6:0] == OP_R);
            end
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready
                         && (r_wait != WAIT_MAX)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
            if (w_pc_we)       r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Reset forces FETCH, whose request must still be masked while reset is held.
    assign mem_req    = w_mem_req & ~reset;
    assign ir_we      = w_ir_we   & ~reset;
    assign pc_we      = w_pc_we   & ~reset;
    assign pc_src     = w_pc_src  & ~reset;
    assign rf_we      = w_rf_we   & ~reset;
    assign dm_we      = w_dm_we   & ~reset;
    assign sel_a      = w_sel_a   & ~reset;
    assign sel_b      = w_sel_b   & ~reset;
    assign wb_sel     = w_wb_sel  & {2{~reset}};
    assign alu_func3  = r_funct3;
    assign alu_subsra = r_subsra;
    assign illegal    = r_illegal;
    assign timeout    = r_timeout;
    assign retired    = r_retired;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction vector table expanded into a per-cycle
// scoreboard queue of stimulus and expected outputs, plus hand-written reset/trap sequences.
module tb_multicycle_sequencer;

    localparam int TO    = 16;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [31:0]      instr;
    logic             mem_ready;
    logic             branch_taken;
    logic             mem_req;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             rf_we;
    logic             dm_we;
    logic             sel_a;
    logic             sel_b;
    logic [1:0]       wb_sel;
    logic [2:0]       alu_func3;
    logic             alu_subsra;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .dm_we        (dm_we),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .wb_sel       (wb_sel),
        .alu_func3    (alu_func3),
        .alu_subsra   (alu_subsra),
        .illegal      (illegal),
        .timeout      (timeout),
        .retired      (retired),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {mem_req, ir_we, pc_we, pc_src, rf_we, dm_we, wb_sel}
    // sel = {sel_a, sel_b, alu_subsra, alu_func3}
    typedef struct {
        logic             rdy;
        logic             bt;
        logic [2:0]       st;
        logic [7:0]       en;
        logic             chk_sel;
        logic [5:0]       sel;
        logic             ill;
        logic             tmo;
        logic [CNT_W-1:0] ret;
    } step_t;

    typedef struct {
        logic [31:0] instr;
        logic        bt;
        int          f_stall;
        int          m_stall;
    } vec_t;

    step_t            sb_q[$];
    logic [CNT_W-1:0] m_ret;
    logic             m_ill;
    logic             m_tmo;
    int               n_checks;
    int               n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic push_step(input logic rdy, input logic bt, input logic [2:0] st,
                             input logic [7:0] en, input logic chk_sel, input logic [5:0] sel);
        step_t s;
        s.rdy = rdy; s.bt = bt; s.st = st; s.en = en; s.chk_sel = chk_sel; s.sel = sel;
        s.ill = m_ill; s.tmo = m_tmo; s.ret = m_ret;
        sb_q.push_back(s);
        if (en[5]) m_ret = m_ret + CNT_W'(1);
    endtask

    task automatic push_trap();
        for (int i = 0; i < 3; i++) push_step(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 6'd0);
    endtask

    // One FETCH or MEM wait: stall cycles with ready low, then ready, or a trap at the limit.
    task automatic push_wait(input logic [2:0] st, input int stall, input logic store,
                             input logic [7:0] done_en, output bit trapped);
        logic       rdy;
        logic [7:0] en;
        trapped = 1'b0;
        for (int i = 0; i <= TO; i++) begin
            rdy = (i >= stall);
            en  = 8'h80 | (store ? 8'h04 : 8'h00) | (rdy ? done_en : 8'h00);
            push_step(rdy, 1'b0, st, en, 1'b0, 6'd0);
            if (rdy) break;
            if (i == TO) begin
                trapped = 1'b1;
                m_tmo   = 1'b1;
            end
        end
    endtask

    task automatic gen_instr(input vec_t v);
        logic [6:0] opc;
        logic       is_r, is_i, is_ld, is_st, is_br;
        logic [7:0] en;
        bit         trapped;
        opc   = v.instr[6:0];
        is_r  = (opc == 7'h33);
        is_i  = (opc == 7'h13);
        is_ld = (opc == 7'h03);
        is_st = (opc == 7'h23);
        is_br = (opc == 7'h63);
        push_wait(3'd0, v.f_stall, 1'b0, 8'h40, trapped);
        if (trapped) begin
            push_trap();
            return;
        end
        push_step(1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 6'd0);
        if (!(is_r || is_i || is_ld || is_st || is_br)) begin
            m_ill = 1'b1;
            push_trap();
            return;
        end
        en = is_br ? (8'h20 | (v.bt ? 8'h10 : 8'h00)) : 8'h00;
        push_step(1'b0, v.bt, 3'd2, en, 1'b1,
                  {~is_br, ~is_r, is_r & v.instr[30], v.instr[14:12]});
        if (is_br) return;
        if (is_ld || is_st) begin
            push_wait(3'd3, v.m_stall, is_st, is_st ? 8'h20 : 8'h00, trapped);
            if (trapped) begin
                push_trap();
                return;
            end
            if (is_st) return;
        end
        push_step(1'b0, 1'b0, 3'd4, is_ld ? 8'h28 : 8'h29, 1'b0, 6'd0);
    endtask

    task automatic run_queue();
        step_t s;
        while (sb_q.size() > 0) begin
            s            = sb_q.pop_front();
            mem_ready    = s.rdy;
            branch_taken = s.bt;
            @(negedge clk);
            check("state", 32'(state), 32'(s.st));
            check("enables", 32'({mem_req, ir_we, pc_we, pc_src, rf_we, dm_we, wb_sel}), 32'(s.en));
            check("flags", 32'({illegal, timeout}), 32'({s.ill, s.tmo}));
            check("retired", 32'(retired), 32'(s.ret));
            if (s.chk_sel)
                check("operands", 32'({sel_a, sel_b, alu_subsra, alu_func3}), 32'(s.sel));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outputs",
              32'({mem_req, ir_we, pc_we, pc_src, rf_we, dm_we, sel_a, sel_b, wb_sel}), 32'd0);
        check("reset_flags", 32'({illegal, timeout, alu_subsra, alu_func3}), 32'd0);
        check("reset_retired", 32'(retired), 32'd0);
        reset = 1'b0;
        m_ret = '0;
        m_ill = 1'b0;
        m_tmo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        vecs[0] = '{32'h002081B3, 1'b0, 0, 0};   // add
        vecs[1] = '{32'h0000A103, 1'b0, 0, 3};   // lw, three MEM stalls
        vecs[2] = '{32'h0020A023, 1'b0, 0, 0};   // sw
        vecs[3] = '{32'h00208463, 1'b1, 0, 0};   // beq taken
        vecs[4] = '{32'h00208463, 1'b0, 0, 0};   // beq not taken
        vecs[5] = '{32'h402081B3, 1'b0, 1, 0};   // sub, fetch stall
        vecs[6] = '{32'h4010D093, 1'b0, 2, 0};   // srai: bit30 set but not R-type
        vecs[7] = '{32'h0000A103, 1'b0, TO, 0};  // ready exactly at fetch limit
        vecs[8] = '{32'h0020A023, 1'b0, 0, TO};  // ready exactly at MEM limit
        vecs[9] = '{32'h00500093, 1'b0, 0, 0};   // addi

        n_checks = 0;
        n_errors = 0;
        instr    = 32'd0;
        m_ret    = '0;
        m_ill    = 1'b0;
        m_tmo    = 1'b0;
        apply_reset();

        // Two passes retire 20 instructions, wrapping the 4-bit counter.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) begin
                instr = vecs[i].instr;
                gen_instr(vecs[i]);
                run_queue();
            end
        end

        instr = 32'h0000006F;
        v = '{32'h0000006F, 1'b0, 0, 0};
        gen_instr(v);
        run_queue();
        apply_reset();

        instr = 32'h002081B3;
        v = '{32'h002081B3, 1'b0, TO + 1, 0};
        gen_instr(v);
        run_queue();
        apply_reset();

        instr = 32'h0000A103;
        v = '{32'h0000A103, 1'b0, 0, TO + 1};
        gen_instr(v);
        run_queue();
        apply_reset();

        // Reset asserted mid-MEM of a store must kill the request and write at once.
        instr     = 32'h0020A023;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_mem_state", 32'(state), 32'd3);
        check("mid_mem_req_we", 32'({mem_req, dm_we}), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("abort_outputs", 32'({mem_req, dm_we, pc_we, rf_we}), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        check("abort_retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_abort_fetch", 32'({state, mem_req}), 32'({3'd0, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
